// File: rtl/dmem_responder.sv
// Data-memory responder: single outstanding load/store against a word RAM,
// with byte/half extraction, byte-lane masked stores and programmable wait states.
module dmem_responder #(
    parameter int ADDR_WIDTH  = 12,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_read,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);
    localparam int AW = ADDR_WIDTH + 2;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t          r_state, w_next;
    logic [AW-1:0]   r_addr;
    logic            r_read;
    logic [2:0]      r_f3;
    logic [31:0]     r_wdata;
    logic [3:0]      r_cnt;
    logic [31:0]     r_rsp_rdata;
    logic            r_rsp_err;
    logic [31:0]     r_mem [2**ADDR_WIDTH];

    logic            w_accept, w_err, w_access;
    logic [AW-1:0]   w_addr;
    logic            w_read;
    logic [2:0]      w_f3;
    logic [31:0]     w_wdata, w_word, w_load, w_wlane;
    logic [7:0]      w_byte;
    logic [15:0]     w_half;
    logic [3:0]      w_be;

    assign req_ready = (r_state == IDLE) & ~rst;
    assign w_accept  = req_valid & req_ready;
    assign rsp_valid = (r_state == RESP);
    assign busy      = (r_state != IDLE);
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;

    always_comb begin
        w_err = 1'b0;
        if (req_read == req_write)                                      w_err = 1'b1;
        if (req_read && (req_funct3 == 3'b011 || req_funct3[2:1] == 2'b11)) w_err = 1'b1;
        if (req_write && req_funct3 > 3'b010)                           w_err = 1'b1;
        if (req_funct3[1:0] == 2'b01 && req_addr[0])                    w_err = 1'b1;
        if (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00)         w_err = 1'b1;
        if (req_addr[31:AW] != '0)                                      w_err = 1'b1;
    end

    // With zero wait states the access uses the live request on the accept edge.
    assign w_addr  = (r_state == IDLE) ? req_addr[AW-1:0] : r_addr;
    assign w_read  = (r_state == IDLE) ? req_read         : r_read;
    assign w_f3    = (r_state == IDLE) ? req_funct3       : r_f3;
    assign w_wdata = (r_state == IDLE) ? req_wdata        : r_wdata;

    assign w_access = ~rst & (((r_state == IDLE) & w_accept & ~w_err & (WAIT_STATES == 0)) |
                              ((r_state == WAIT) & (r_cnt == 4'd1)));

    assign w_word = r_mem[w_addr[AW-1:2]];
    assign w_byte = w_word[8*w_addr[1:0] +: 8];
    assign w_half = w_addr[1] ? w_word[31:16] : w_word[15:0];

    always_comb begin
        w_load = w_word;
        unique case (w_f3)
            3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_load = {24'd0, w_byte};
            3'b001:  w_load = {{16{w_half[15]}}, w_half};
            3'b101:  w_load = {16'd0, w_half};
            default: w_load = w_word;
        endcase
    end

    always_comb begin
        w_be    = 4'b1111;
        w_wlane = w_wdata;
        unique case (w_f3[1:0])
            2'b00: begin
                w_be    = 4'b0001 << w_addr[1:0];
                w_wlane = {4{w_wdata[7:0]}};
            end
            2'b01: begin
                w_be    = w_addr[1] ? 4'b1100 : 4'b0011;
                w_wlane = {2{w_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    // RAM is deliberately outside reset; a reset edge suppresses the write via w_access.
    always_ff @(posedge clk) begin
        if (w_access && !w_read) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) r_mem[w_addr[AW-1:2]][8*i +: 8] <= w_wlane[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (w_accept) w_next = (w_err || WAIT_STATES == 0) ? RESP : WAIT;
            WAIT:    if (r_cnt == 4'd1) w_next = RESP;
            RESP:    if (rsp_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr      <= '0;
            r_read      <= 1'b0;
            r_f3        <= 3'd0;
            r_wdata     <= 32'd0;
            r_cnt       <= 4'd0;
            r_rsp_rdata <= 32'd0;
            r_rsp_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_addr      <= req_addr[AW-1:0];
                r_read      <= req_read;
                r_f3        <= req_funct3;
                r_wdata     <= req_wdata;
                r_cnt       <= 4'(WAIT_STATES);
                r_rsp_err   <= w_err;
                r_rsp_rdata <= 32'd0;
            end else if (r_state == WAIT) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_access) r_rsp_rdata <= w_read ? w_load : 32'd0;
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances (1, 3 and 0 wait states)
// checked against a scoreboard of expected responses and latencies.
module tb_dmem_responder;
    localparam int NI = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [NI-1:0] rst, req_valid, req_read, req_write, rsp_ready;
    logic [31:0]   req_addr [NI];
    logic [31:0]   req_wdata [NI];
    logic [2:0]    req_funct3 [NI];
    wire  [NI-1:0] req_ready, rsp_valid, rsp_err, busy;
    wire  [31:0]   rsp_rdata [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int WS = (g == 0) ? 1 : (g == 1) ? 3 : 0;
        dmem_responder #(.ADDR_WIDTH(12), .WAIT_STATES(WS)) u_dut (
            .clk(clk), .rst(rst[g]),
            .req_valid(req_valid[g]), .req_ready(req_ready[g]),
            .req_addr(req_addr[g]), .req_read(req_read[g]), .req_write(req_write[g]),
            .req_funct3(req_funct3[g]), .req_wdata(req_wdata[g]),
            .rsp_valid(rsp_valid[g]), .rsp_ready(rsp_ready[g]),
            .rsp_rdata(rsp_rdata[g]), .rsp_err(rsp_err[g]), .busy(busy[g])
        );
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;
    exp_t sb[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int k, input bit rd, input bit wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
        req_valid[k]  = 1'b1;
        req_read[k]   = rd;
        req_write[k]  = wr;
        req_funct3[k] = f3;
        req_addr[k]   = a;
        req_wdata[k]  = wd;
    endtask

    // Called at a negedge with instance k idle; returns at a negedge with it idle again.
    task automatic go(input int k, input bit rd, input bit wr, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] wd,
                      input logic [31:0] exp_rd, input bit exp_er, input int lat,
                      input string tag, output int acc_cyc);
        exp_t e;
        int   n;
        sb.push_back('{exp_rd, exp_er, lat});
        drive(k, rd, wr, f3, a, wd);
        rsp_ready[k] = 1'b1;
        chk({tag, "/req_ready"}, 32'(req_ready[k]), 32'd1);
        acc_cyc = cyc;
        @(posedge clk);
        @(negedge clk);
        req_valid[k] = 1'b0;
        n = 1;
        while (!rsp_valid[k] && n < 40) begin
            @(negedge clk);
            n++;
        end
        e = sb.pop_front();
        chk({tag, "/latency"}, 32'(n), 32'(e.lat));
        chk({tag, "/rdata"}, rsp_rdata[k], e.rdata);
        chk({tag, "/err"}, 32'(rsp_err[k]), 32'(e.err));
        @(negedge clk);
        chk({tag, "/busy_after"}, 32'(busy[k]), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        int a1, a2, n;
        rst       = '1;
        req_valid = '0;
        req_read  = '0;
        req_write = '0;
        rsp_ready = '1;
        for (int k = 0; k < NI; k++) begin
            req_addr[k]   = 32'd0;
            req_wdata[k]  = 32'd0;
            req_funct3[k] = 3'd0;
        end
        #1;
        for (int k = 0; k < NI; k++) begin
            chk($sformatf("reset%0d/req_ready", k), 32'(req_ready[k]), 32'd0);
            chk($sformatf("reset%0d/rsp_valid", k), 32'(rsp_valid[k]), 32'd0);
            chk($sformatf("reset%0d/rsp_rdata", k), rsp_rdata[k], 32'd0);
            chk($sformatf("reset%0d/rsp_err", k), 32'(rsp_err[k]), 32'd0);
            chk($sformatf("reset%0d/busy", k), 32'(busy[k]), 32'd0);
        end
        repeat (3) @(negedge clk);
        rst = '0;
        @(negedge clk);

        // 1 wait state: basic store/load and lane handling
        go(0, 0, 1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0,        0, 2, "sw10", a1);
        go(0, 1, 0, 3'b010, 32'h10, 32'h0,        32'hDEADBEEF, 0, 2, "lw10", a1);
        go(0, 0, 1, 3'b000, 32'h13, 32'h00000080, 32'h0,        0, 2, "sb13", a1);
        go(0, 1, 0, 3'b000, 32'h13, 32'h0,        32'hFFFFFF80, 0, 2, "lb13", a1);
        go(0, 1, 0, 3'b100, 32'h13, 32'h0,        32'h00000080, 0, 2, "lbu13", a1);
        go(0, 1, 0, 3'b010, 32'h10, 32'h0,        32'h80ADBEEF, 0, 2, "lw10b", a1);
        go(0, 1, 0, 3'b101, 32'h12, 32'h0,        32'h000080AD, 0, 2, "lhu12", a1);
        go(0, 1, 0, 3'b001, 32'h12, 32'h0,        32'hFFFF80AD, 0, 2, "lh12", a1);

        // rejected requests: one-cycle error response, no side effect
        go(0, 1, 0, 3'b001, 32'h11,   32'h0,        32'h0, 1, 1, "lh11", a1);
        go(0, 0, 1, 3'b010, 32'h12,   32'hFFFFFFFF, 32'h0, 1, 1, "sw12", a1);
        go(0, 1, 1, 3'b010, 32'h10,   32'h12345678, 32'h0, 1, 1, "rdwr", a1);
        go(0, 0, 0, 3'b010, 32'h10,   32'h0,        32'h0, 1, 1, "none", a1);
        go(0, 1, 0, 3'b010, 32'h4000, 32'h0,        32'h0, 1, 1, "lw4000", a1);
        go(0, 1, 0, 3'b011, 32'h10,   32'h0,        32'h0, 1, 1, "ld011", a1);
        go(0, 0, 1, 3'b100, 32'h10,   32'h0,        32'h0, 1, 1, "st100", a1);
        go(0, 1, 0, 3'b010, 32'h10,   32'h0,        32'h80ADBEEF, 0, 2, "lw10c", a1);

        // backpressure: response held 5 cycles while a competing request is offered
        rsp_ready[0] = 1'b0;
        drive(0, 1, 0, 3'b010, 32'h10, 32'h0);
        @(posedge clk);
        @(negedge clk);
        req_valid[0] = 1'b0;
        n = 1;
        while (!rsp_valid[0] && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("bp/latency", 32'(n), 32'd2);
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 1, 3'b010, 32'h10, 32'h0);
            @(negedge clk);
            chk($sformatf("bp%0d/rsp_valid", i), 32'(rsp_valid[0]), 32'd1);
            chk($sformatf("bp%0d/rsp_rdata", i), rsp_rdata[0], 32'h80ADBEEF);
            chk($sformatf("bp%0d/rsp_err", i), 32'(rsp_err[0]), 32'd0);
            chk($sformatf("bp%0d/req_ready", i), 32'(req_ready[0]), 32'd0);
        end
        req_valid[0] = 1'b0;
        rsp_ready[0] = 1'b1;
        @(negedge clk);
        chk("bp/busy_after", 32'(busy[0]), 32'd0);
        chk("bp/rsp_valid_after", 32'(rsp_valid[0]), 32'd0);
        go(0, 1, 0, 3'b010, 32'h10, 32'h0, 32'h80ADBEEF, 0, 2, "bp/lw10", a1);

        // 3 wait states: reset during WAIT drops the pending store
        go(1, 0, 1, 3'b010, 32'h20, 32'hCAFEF00D, 32'h0, 0, 4, "ws3/sw20", a1);
        drive(1, 0, 1, 3'b010, 32'h20, 32'h11223344);
        @(posedge clk);
        @(negedge clk);
        req_valid[1] = 1'b0;
        chk("ws3/busy_wait", 32'(busy[1]), 32'd1);
        @(negedge clk);
        rst[1] = 1'b1;
        #1;
        chk("rstmid/rsp_valid", 32'(rsp_valid[1]), 32'd0);
        chk("rstmid/rsp_rdata", rsp_rdata[1], 32'd0);
        chk("rstmid/rsp_err", 32'(rsp_err[1]), 32'd0);
        chk("rstmid/busy", 32'(busy[1]), 32'd0);
        chk("rstmid/req_ready", 32'(req_ready[1]), 32'd0);
        repeat (3) @(negedge clk);
        rst[1] = 1'b0;
        @(negedge clk);
        go(1, 1, 0, 3'b010, 32'h20, 32'h0, 32'hCAFEF00D, 0, 4, "ws3/lw20", a1);

        // 0 wait states: back-to-back store then load
        go(2, 0, 1, 3'b010, 32'h8, 32'hA5A55A5A, 32'h0,        0, 1, "ws0/sw8", a1);
        go(2, 1, 0, 3'b010, 32'h8, 32'h0,        32'hA5A55A5A, 0, 1, "ws0/lw8", a2);
        chk("ws0/accept_spacing", 32'(a2 - a1), 32'd2);
        go(2, 1, 0, 3'b000, 32'h9, 32'h0,        32'h0000005A, 0, 1, "ws0/lb9", a1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the RV32 core: the memory-side end of the executor's load/store interface. Accepts one load or store request at a time and, for loads, extracts the byte, halfword or word and sign- or zero-extends it. Stores are byte-lane masked into an internal word-organised RAM. Responses arrive after a programmable number of wait states, so the pipeline is exercised against realistic memory latency.

## Interface
- ADDR_WIDTH, 12, word-address bits; RAM holds 2**ADDR_WIDTH 32-bit words (byte range 0 .. 2**(ADDR_WIDTH+2)-1)
- WAIT_STATES, 1, extra cycles between acceptance and response for valid accesses (0..15)

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  responder can accept
- req_addr  in  32  byte address
- req_read  in  1  load request
- req_write  in  1  store request
- req_funct3  in  3  RV32 load/store funct3
- req_wdata  in  32  store data, LSB-aligned
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer takes response
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- rsp_err  out  1  request rejected, no memory side effect
- busy  out  1  state != IDLE

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: req_ready=1. Handshake is req_valid & req_ready at a rising edge. On acceptance, latch addr, read/write, funct3 and wdata.
- Error check at acceptance, any of the following sets err:
  - req_read == req_write (both or neither asserted)
  - load funct3 in {011,110,111}
  - store funct3 > 010
  - halfword access with addr[0]=1
  - word access with addr[1:0]≠0
  - addr[31:ADDR_WIDTH+2] ≠ 0
- Error path: go to RESP with rsp_err=1, rsp_rdata=0. No RAM access.
- Valid path: go to WAIT with counter=WAIT_STATES. If WAIT_STATES=0, go directly to RESP and do the access on that edge.
- WAIT: decrement each cycle. On the edge where counter==1 (or on acceptance when WAIT_STATES=0), perform the access, enter RESP and register the outputs.
- Loads, with lane selected by addr[1:0]:
  - LB (000): sign-extend the byte.
  - LBU (100): zero-extend the byte.
  - LH (001): half selected by addr[1], sign-extended.
  - LHU (101): half selected by addr[1], zero-extended.
  - LW (010): the whole word.
- Stores:
  - SB writes wdata[7:0] to lane addr[1:0].
  - SH writes wdata[15:0] to half addr[1].
  - SW writes the whole word.
  - Other lanes are untouched. rsp_rdata=0.
- RESP: rsp_valid=1. rsp_rdata and rsp_err are held stable until rsp_valid & rsp_ready, then return to IDLE. req_ready=0 outside IDLE; requests offered then are ignored.
- RAM contents are not affected by rst and are undefined at power-up.

## Timing
- Reset values: state=IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0, req_ready=0 while rst is high and 1 after release.
- Latency, with acceptance at edge T:
  - valid request: rsp_valid rises after edge T+1+WAIT_STATES-1, i.e. visible in cycle T+1+WAIT_STATES.
  - error request: rsp_valid rises in cycle T+1.
- Throughput: with rsp_ready held at 1, at most one request per WAIT_STATES+2 cycles. The return to IDLE costs one cycle; there is no accept in the handshake-out cycle.
- Reset mid-operation: a pending store in WAIT is dropped and the RAM is not written. A response in RESP is discarded. Outputs take their reset values asynchronously.
- Counter is 4 bits. WAIT_STATES>15 is unsupported.

## Test plan
- WAIT_STATES=1. SW 0xDEADBEEF to 0x10, then LW 0x10. Required: rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_valid in cycle T+2 for each.
- SB wdata=0x00000080 to 0x13. Then:
  - LB 0x13 -> 0xFFFFFF80
  - LBU 0x13 -> 0x00000080
  - LW 0x10 -> 0x80ADBEEF
  - LHU 0x12 -> 0x000080AD
- Misaligned and illegal requests, each giving rsp_err=1, rsp_rdata=0, rsp_valid in cycle T+1, with a following LW 0x10 unchanged:
  - LH 0x11
  - SW 0x12
  - req_read=req_write=1
  - LW 0x4000 (ADDR_WIDTH=12)
- Backpressure: hold rsp_ready=0 for 5 cycles after LW 0x10. Required: rsp_valid, rsp_rdata and rsp_err stable; req_ready=0; a concurrent request is ignored. Release: one handshake, then IDLE with busy=0.
- WAIT_STATES=3. Assert rst during the second WAIT cycle of SW 0x11223344 to 0x20. Required: outputs at reset values immediately. After release, LW 0x20 returns the prior value and completes in T+4.
- WAIT_STATES=0. Back-to-back SW then LW to 0x8. Required: LW response in cycle T+1 carrying the stored data; consecutive accepts are 2 cycles apart.
